uart_tx_arbiter: RTL

//  Shares one UART transmitter byte stream between NUM_REQ requesters (message generators,
//  RX echo path, status reporter). Grants are round-robin and message-locked: once granted,
//  a requester owns the TX stream until its byte with req_last is accepted. An optional

---
 rtl/uart_pkg.sv | 17 +
 rtl/rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART TX arbiter
// Arbiter FSM encoding plus a width helper for counters that must never collapse to zero bits.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_XFER,
    ARB_GAP
  } arb_state_t;

  function automatic int clog2_min1(input int value);
    return (value < 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Returns the first set request scanning ptr, ptr+1, ... modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // Rotate so bit 0 is the requester at ptr; the lowest set bit then wins.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any = 1'b1;
        idx = W'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-locked round-robin arbiter for one UART TX byte stream
// A granted requester owns the stream until req_last or MAX_MSG_LEN bytes, then an optional settle gap.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYCLES  = 16,
  parameter int MAX_MSG_LEN = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]         tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic                           overrun_err
);

  localparam int GID_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_MSG_LEN + 1);
  localparam int GAP_W = clog2_min1(GAP_CYCLES + 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [GID_W-1:0] rr_ptr;
  logic [GID_W-1:0] ptr_after;
  logic [CNT_W-1:0] byte_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [GID_W-1:0] pick_idx;
  logic             pick_any;
  logic             hs;
  logic             cur_last;
  logic             hit_max;
  logic             msg_end;

  logic [UART_BYTE_W-1:0] req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = req_data[g*UART_BYTE_W +: UART_BYTE_W];
  end

  rr_pick #(
    .N (NUM_REQ),
    .W (GID_W)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign hs        = tx_valid & tx_ready;
  assign cur_last  = req_last[grant_id];
  assign hit_max   = (byte_cnt == CNT_W'(MAX_MSG_LEN - 1));
  assign msg_end   = hs & (cur_last | hit_max);
  assign ptr_after = (grant_id == GID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign busy      = (state != ARB_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_nxt = ARB_XFER;
        end
      end
      ARB_XFER: begin
        if (msg_end) begin
          state_nxt = (GAP_CYCLES > 0) ? ARB_GAP : ARB_IDLE;
        end
      end
      ARB_GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // The owner is wired straight through; a stalled owner simply holds the grant.
  always_comb begin
    tx_data   = '0;
    tx_valid  = 1'b0;
    req_ready = '0;
    if (state == ARB_XFER) begin
      tx_data             = req_bytes[grant_id];
      tx_valid            = req_valid[grant_id];
      req_ready[grant_id] = tx_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      grant_id    <= '0;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= hs & ~cur_last & hit_max;
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_id <= pick_idx;
            byte_cnt <= '0;
          end
        end
        ARB_XFER: begin
          if (hs) begin
            byte_cnt <= byte_cnt + 1'b1;
          end
          if (msg_end) begin
            rr_ptr  <= ptr_after;
            gap_cnt <= '0;
          end
        end
        ARB_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        default: begin
          gap_cnt <= '0;
        end
      endcase
    end
  end

endmodule
